// File: rtl/timer_bank_if.sv
// Processor bus bundle for timer_bank.
//   PrAddr : byte address (master -> slave)
//   PrWD   : write data (master -> slave)
//   we     : write strobe, sampled on the rising clock edge (master -> slave)
//   PrRD   : combinational read data (slave -> master)
//   HWInt  : per-channel interrupt lines, bit i = channel i (slave -> master)
interface timer_bank_if;
  logic [31:0] PrAddr;
  logic [31:0] PrWD;
  logic        we;
  logic [31:0] PrRD;
  logic [5:0]  HWInt;

  modport master (
    output PrAddr,
    output PrWD,
    output we,
    input  PrRD,
    input  HWInt
  );

  modport slave (
    input  PrAddr,
    input  PrWD,
    input  we,
    output PrRD,
    output HWInt
  );
endinterface

// File: rtl/timer_bank.sv
// Bank of NCH independent down-counting timers on a simple processor bus.
// Each channel has a 16-byte window at BASE + 16*i with four word registers:
//   +0x0 CTRL   {IM, MODE[1:0], EN}
//   +0x4 PRESET reload value (CW bits)
//   +0x8 COUNT  current count, read-only
//   +0xC STATUS bit0 PEND, write 1 to clear
// Ports:
//   clk : system clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : slave side of timer_bank_if (PrAddr, PrWD, we, PrRD, HWInt)
module timer_bank #(
  parameter int unsigned NCH  = 2,
  parameter logic [31:0] BASE = 32'h0000_7F00,
  parameter int unsigned CW   = 32
) (
  input logic         clk,
  input logic         rst,
  timer_bank_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

  localparam logic [CW-1:0] CntOne = CW'(1);

  // Address decode. BASE is 16-byte aligned, so the low offset bits match PrAddr.
  // An address below BASE wraps to a huge offset and falls out of range.
  logic [31:0]    offset;
  logic           hit;
  logic [2:0]     ch_sel;
  logic [1:0]     reg_sel;
  logic [NCH-1:0] wr_ch;

  assign offset  = bus.PrAddr - BASE;
  assign hit     = offset < 32'(16 * NCH);
  assign ch_sel  = offset[6:4];
  assign reg_sel = offset[3:2];

  always_comb begin
    wr_ch = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_ch[i] = bus.we & hit & (ch_sel == 3'(i));
    end
  end

  // Per-channel state
  logic [3:0]     ctrl_q   [NCH];
  logic [CW-1:0]  preset_q [NCH];
  logic [CW-1:0]  count_q  [NCH];
  logic [NCH-1:0] pend_q;
  state_e         state_q  [NCH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        ctrl_q[i]   <= '0;
        preset_q[i] <= '0;
        count_q[i]  <= '0;
        state_q[i]  <= StIdle;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        // STATUS clear is placed before the FSM so a same-cycle PEND set wins.
        if (wr_ch[i] && reg_sel == 2'd3 && bus.PrWD[0]) begin
          pend_q[i] <= 1'b0;
        end

        case (state_q[i])
          StIdle: begin
            if (ctrl_q[i][0]) state_q[i] <= StLoad;
          end
          StLoad: begin
            count_q[i] <= preset_q[i];
            state_q[i] <= StCnt;
          end
          StCnt: begin
            if (!ctrl_q[i][0]) begin
              state_q[i] <= StIdle;
            end else if (count_q[i] > CntOne) begin
              count_q[i] <= count_q[i] - CntOne;
            end else begin
              // COUNT of 0 or 1 both expire here, so PRESET=0 acts like 1.
              count_q[i] <= '0;
              pend_q[i]  <= 1'b1;
              state_q[i] <= StInt;
            end
          end
          StInt: begin
            if (ctrl_q[i][2:1] == 2'b01) begin
              state_q[i] <= StLoad;
            end else begin
              ctrl_q[i][0] <= 1'b0;
              state_q[i]   <= StIdle;
            end
          end
          default: state_q[i] <= StIdle;
        endcase

        // Bus writes follow the FSM so a CTRL write overrides the one-shot EN clear.
        if (wr_ch[i]) begin
          if (reg_sel == 2'd0) ctrl_q[i]   <= bus.PrWD[3:0];
          if (reg_sel == 2'd1) preset_q[i] <= bus.PrWD[CW-1:0];
        end
      end
    end
  end

  // Read mux, combinational from the current address and registers.
  logic [31:0] rd;

  always_comb begin
    rd = '0;
    for (int i = 0; i < NCH; i++) begin
      if (hit && ch_sel == 3'(i)) begin
        case (reg_sel)
          2'd0:    rd[3:0]    = ctrl_q[i];
          2'd1:    rd[CW-1:0] = preset_q[i];
          2'd2:    rd[CW-1:0] = count_q[i];
          default: rd[0]      = pend_q[i];
        endcase
      end
    end
  end

  assign bus.PrRD = rd;

  // Interrupts come only from registered state.
  logic [5:0] irq;

  always_comb begin
    irq = '0;
    for (int i = 0; i < NCH; i++) begin
      irq[i] = pend_q[i] & ctrl_q[i][3];
    end
  end

  assign bus.HWInt = irq;

  // Upper write-data bits have no destination.
  logic unused_wd;
  assign unused_wd = ^bus.PrWD;

endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;

  localparam int unsigned NCH  = 3;
  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam int unsigned CW   = 8;
  localparam logic [31:0] Mask = (32'd1 << CW) - 32'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  timer_bank_if bus ();

  timer_bank #(
    .NCH  (NCH),
    .BASE (BASE),
    .CW   (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: register contents plus which step of the timer
  // sequence each channel is in (0 idle, 1 load, 2 counting, 3 expired).
  logic        m_en     [NCH];
  logic [1:0]  m_mode   [NCH];
  logic        m_im     [NCH];
  logic [31:0] m_preset [NCH];
  logic [31:0] m_count  [NCH];
  logic        m_pend   [NCH];
  int          m_ph     [NCH];
  bit          m_known = 1'b0;

  typedef struct {
    int unsigned cyc;
    logic [31:0] rd;
    logic [5:0]  irq;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc_n = 0;
  int          tests = 0;
  int          fails = 0;

  function automatic logic [31:0] adr(input int ch, input int rg);
    return BASE + 32'(16 * ch) + 32'(4 * rg);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    longint off;
    int     ch;
    off = longint'(a) - longint'(BASE);
    if (off < 0 || off >= longint'(16 * NCH)) return 32'd0;
    ch = int'(off / 16);
    case (a[3:2])
      2'd0:    return {28'd0, m_im[ch], m_mode[ch], m_en[ch]};
      2'd1:    return m_preset[ch];
      2'd2:    return m_count[ch];
      default: return {31'd0, m_pend[ch]};
    endcase
  endfunction

  function automatic logic [5:0] model_irq();
    logic [5:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[i] = m_pend[i] & m_im[i];
    return v;
  endfunction

  // Advance the model across one rising edge with the inputs held during the cycle.
  function automatic void model_step(input logic [31:0] a, input logic [31:0] d,
                                     input logic w, input logic r);
    longint off;
    bit     hit;
    int     ch;
    bit     en_clr;
    bit     pend_set;
    if (r) begin
      for (int i = 0; i < NCH; i++) begin
        m_en[i] = 0; m_mode[i] = 0; m_im[i] = 0; m_preset[i] = 0;
        m_count[i] = 0; m_pend[i] = 0; m_ph[i] = 0;
      end
      m_known = 1'b1;
      return;
    end
    off = longint'(a) - longint'(BASE);
    hit = (off >= 0) && (off < longint'(16 * NCH));
    ch  = hit ? int'(off / 16) : -1;
    for (int i = 0; i < NCH; i++) begin
      en_clr   = 0;
      pend_set = 0;
      case (m_ph[i])
        0: if (m_en[i]) m_ph[i] = 1;
        1: begin m_count[i] = m_preset[i]; m_ph[i] = 2; end
        2: begin
          if (!m_en[i]) m_ph[i] = 0;
          else if (m_count[i] > 1) m_count[i] = m_count[i] - 1;
          else begin m_count[i] = 0; pend_set = 1; m_ph[i] = 3; end
        end
        default: begin
          if (m_mode[i] == 2'b01) m_ph[i] = 1;
          else begin en_clr = 1; m_ph[i] = 0; end
        end
      endcase
      if (en_clr) m_en[i] = 0;
      if (pend_set) m_pend[i] = 1;
      if (w && ch == i) begin
        case (a[3:2])
          2'd0: begin m_en[i] = d[0]; m_mode[i] = d[2:1]; m_im[i] = d[3]; end
          2'd1: m_preset[i] = d & Mask;
          2'd3: if (d[0] && !pend_set) m_pend[i] = 0;
          default: ;
        endcase
      end
    end
  endfunction

  // One bus cycle: drive, queue the model's prediction, then cross the edge.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w,
                     input logic r);
    exp_t e;
    bus.PrAddr = a;
    bus.PrWD   = d;
    bus.we     = w;
    rst        = r;
    if (m_known) begin
      e.cyc = cyc_n; e.rd = model_rd(a); e.irq = model_irq(); e.name = "model";
      sb.push_back(e);
    end
    @(posedge clk);
    model_step(a, d, w, r);
    cyc_n++;
    #1;
  endtask

  // Read cycle with an additional fixed expectation.
  task automatic cycp(input logic [31:0] a, input logic [31:0] rd, input logic [5:0] irq,
                      input string name);
    exp_t e;
    e.cyc = cyc_n; e.rd = rd; e.irq = irq; e.name = name;
    sb.push_back(e);
    cyc(a, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: condition not reached within cycle budget (got timeout, required event)",
             name);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc == cyc_n) begin
      mon_e = sb.pop_front();
      tests++;
      if (bus.PrRD !== mon_e.rd || bus.HWInt !== mon_e.irq) begin
        fails++;
        $display("FAIL %s cyc %0d addr %h: got PrRD=%h HWInt=%b, required PrRD=%h HWInt=%b",
                 mon_e.name, cyc_n, bus.PrAddr, bus.PrRD, bus.HWInt, mon_e.rd, mon_e.irq);
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    logic        w, r;
    int          ch, rg;
    bit          done;

    cyc(adr(0, 0), 32'd0, 1'b0, 1'b1);
    cyc(adr(0, 0), 32'd0, 1'b0, 1'b1);

    // All registers zero after reset, out-of-range reads zero.
    for (int c = 0; c < NCH; c++)
      for (int g = 0; g < 4; g++) cycp(adr(c, g), 32'd0, 6'd0, "reset_regs");
    cycp(adr(NCH, 0), 32'd0, 6'd0, "reset_above_range");
    cycp(BASE - 32'd4, 32'd0, 6'd0, "reset_below_range");

    // One-shot channel 0, PRESET=3.
    cyc(adr(0, 1), 32'd3, 1'b1, 1'b0);
    cyc(adr(0, 0), 32'h9, 1'b1, 1'b0);
    cyc(adr(0, 2), 32'd0, 1'b0, 1'b0);
    cyc(adr(0, 2), 32'd0, 1'b0, 1'b0);
    cycp(adr(0, 2), 32'd3, 6'd0, "oneshot_count3");
    cycp(adr(0, 2), 32'd2, 6'd0, "oneshot_count2");
    cycp(adr(0, 2), 32'd1, 6'd0, "oneshot_count1");
    cycp(adr(0, 2), 32'd0, 6'd1, "oneshot_count0_irq");
    cycp(adr(0, 0), 32'h8, 6'd1, "oneshot_en_cleared");
    cycp(adr(0, 3), 32'd1, 6'd1, "oneshot_pend");
    cyc(adr(0, 3), 32'd1, 1'b1, 1'b0);
    cycp(adr(0, 3), 32'd0, 6'd0, "status_clear");
    cycp(adr(NCH, 2), 32'd0, 6'd0, "out_of_range_read");

    // Auto-reload channel 1 with a status clear between events.
    cyc(adr(1, 1), 32'd3, 1'b1, 1'b0);
    cyc(adr(1, 0), 32'hB, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) cyc(adr(1, 3), 32'd0, 1'b0, 1'b0);
    cyc(adr(1, 3), 32'd1, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) cyc(adr(1, 2), 32'd0, 1'b0, 1'b0);
    cycp(adr(0, 0), 32'h8, model_irq(), "ch0_untouched");
    cyc(adr(1, 0), 32'd0, 1'b1, 1'b0);
    cyc(adr(1, 3), 32'd1, 1'b1, 1'b0);

    // Interrupt masked, then unmasked.
    cyc(adr(0, 1), 32'd1, 1'b1, 1'b0);
    cyc(adr(0, 0), 32'h1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) cyc(adr(0, 3), 32'd0, 1'b0, 1'b0);
    cycp(adr(0, 3), 32'd1, 6'd0, "masked_pend");
    cyc(adr(0, 0), 32'h8, 1'b1, 1'b0);
    cycp(adr(0, 3), 32'd1, 6'd1, "unmask_irq");
    cyc(adr(0, 3), 32'd1, 1'b1, 1'b0);

    // Preset write during count, stop, restart; clear colliding with expiry.
    cyc(adr(2, 1), 32'd6, 1'b1, 1'b0);
    cyc(adr(2, 0), 32'h9, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cyc(adr(2, 2), 32'd0, 1'b0, 1'b0);
    cyc(adr(2, 1), 32'd10, 1'b1, 1'b0);
    cyc(adr(2, 0), 32'h8, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cyc(adr(2, 2), 32'd0, 1'b0, 1'b0);
    cyc(adr(2, 0), 32'h9, 1'b1, 1'b0);
    cyc(adr(2, 2), 32'd0, 1'b0, 1'b0);
    cyc(adr(2, 2), 32'd0, 1'b0, 1'b0);
    cycp(adr(2, 2), 32'd10, 6'd0, "reload_new_preset");
    done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      if (m_ph[2] == 2 && m_en[2] && m_count[2] <= 1) begin
        cyc(adr(2, 3), 32'd1, 1'b1, 1'b0);
        cycp(adr(2, 3), 32'd1, 6'b000100, "set_beats_clear");
        done = 1;
      end else begin
        cyc(adr(2, 2), 32'd0, 1'b0, 1'b0);
      end
    end
    if (!done) bound_fail("set_beats_clear");

    // Reset in the middle of a count.
    cyc(adr(0, 1), 32'd5, 1'b1, 1'b0);
    cyc(adr(0, 0), 32'h9, 1'b1, 1'b0);
    done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      if (m_ph[0] == 2 && m_count[0] == 2) begin
        cyc(adr(0, 2), 32'd0, 1'b0, 1'b1);
        done = 1;
      end else begin
        cyc(adr(0, 2), 32'd0, 1'b0, 1'b0);
      end
    end
    if (!done) bound_fail("reset_mid_count");
    for (int k = 0; k < 8; k++) cycp(adr(0, 2), 32'd0, 6'd0, "reset_abort_count");
    cycp(adr(0, 0), 32'd0, 6'd0, "reset_abort_ctrl");
    cycp(adr(2, 3), 32'd0, 6'd0, "reset_abort_pend");

    // Randomized traffic.
    for (int k = 0; k < 4000; k++) begin
      ch = int'($urandom_range(0, NCH));
      rg = int'($urandom_range(0, 3));
      a  = adr(ch, rg) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) a = $urandom;
      d = $urandom;
      if (rg == 1 && $urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 6));
      if (rg == 0 && $urandom_range(0, 2) != 0) d[0] = 1'b1;
      w = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 499) == 0);
      cyc(a, d, w, r);
    end

    cyc(adr(0, 0), 32'd0, 1'b0, 1'b0);
    cyc(adr(0, 0), 32'd0, 1'b0, 1'b0);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d unchecked entries, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameter NCH, default 2, number of timer channels, legal 1..6.
REQ-002 SHALL have parameter BASE, default 32'h0000_7F00, byte address of channel 0; 16-byte aligned.
REQ-003 SHALL have parameter CW, default 32, counter/preset width, legal 8..32.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 PrAddr  input  32  processor byte address.
REQ-007 PrWD  input  32  processor write data.
REQ-008 we  input  1  processor write strobe, sampled on the clock edge.
REQ-009 PrRD  output  32  read data, combinational from PrAddr and current registers.
REQ-010 HWInt  output  6  interrupt lines; bit i = IRQ of channel i; bits NCH..5 tied 0.

Function
REQ-011 Channel i SHALL occupy BASE+16*i .. BASE+16*i+15; PrAddr[3:2] selects 0 CTRL, 1 PRESET, 2 COUNT, 3 STATUS.
REQ-012 Addresses outside BASE .. BASE+16*NCH-1 SHALL be ignored on write and return PrRD=0.
REQ-013 CTRL: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 10/11 treated as one-shot), bit3 IM (interrupt enable); reads return bits[3:0], upper bits 0.
REQ-014 PRESET: write stores PrWD[CW-1:0]; read zero-extended to 32 bits.
REQ-015 COUNT: read-only, zero-extended; writes ignored.
REQ-016 STATUS: bit0 PEND; writing 1 to bit0 clears PEND; writing 0 has no effect.
REQ-017 Each channel SHALL run a FSM with states IDLE, LOAD, CNT, INT.
REQ-018 IDLE: EN=1 -> LOAD; else stay.
REQ-019 LOAD: COUNT<=PRESET -> CNT.
REQ-020 CNT: EN=0 -> IDLE, COUNT held; else COUNT>1 -> COUNT-1, stay; else (COUNT<=1) COUNT<=0, PEND<=1 -> INT.
REQ-021 INT: one-shot -> clear EN, -> IDLE; auto-reload -> LOAD.
REQ-022 IRQ_i SHALL equal PEND_i & IM_i, registered-state only (no combinational path from PrWD).
REQ-023 PRESET=0 SHALL behave as 1: interrupt one cycle after LOAD.
REQ-024 PRESET write during CNT SHALL NOT alter COUNT; takes effect at next LOAD.
REQ-025 CTRL write with EN=0 during CNT SHALL stop the channel at the next edge; re-enabling restarts from LOAD (full preset).
REQ-026 Simultaneous STATUS clear and PEND set in the same cycle: set wins, PEND=1.
REQ-027 Simultaneous CTRL write and INT one-shot EN clear: CTRL write wins.
REQ-028 Auto-reload period SHALL be PRESET+2 cycles between PEND set events (PRESET>=1).
REQ-029 Channels SHALL be fully independent; one write affects only the addressed channel.

Reset
REQ-030 On rst=1 at an edge: every CTRL, PRESET, COUNT, PEND SHALL be 0, every FSM in IDLE, HWInt=6'b0; PrRD reflects zeroed registers.
REQ-031 rst mid-count SHALL abort immediately; no interrupt is generated on release.

Verification
REQ-032 Reset, then read all registers of all channels -> all 0, HWInt=0; read BASE+16*NCH -> 0.
REQ-033 Ch0 PRESET=3, write CTRL=4'b1001 (EN, one-shot, IM) at edge E0 -> COUNT 3,2,1,0 at E2..E5; HWInt[0]=1 after E5; CTRL reads 4'b1000 after E6; state IDLE.
REQ-034 Ch1 PRESET=3, CTRL=4'b1011 (auto-reload) -> PEND set every 5 cycles; write STATUS=1 between events -> HWInt[1] drops next cycle, reasserts at next event; ch0 unaffected.
REQ-035 Counting with IM=0 -> PEND=1 in STATUS, HWInt stays 0; set IM=1 -> HWInt rises next cycle.
REQ-036 During CNT write PRESET=10 then CTRL EN=0 -> COUNT freezes; EN=1 -> LOAD with 10; STATUS clear coinciding with INT -> PEND remains 1.
REQ-037 rst asserted while COUNT=2 -> all zero next cycle, no IRQ thereafter until reprogrammed.
